mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide operations.
- Sits beside the single-cycle ALU in EXU. It accepts one M-extension op when the ALU control code selects a mul/div operation.
- Iterates a shared 32-step shift/add-subtract datapath, then holds the result until the pipeline consumes it.
- Uses a valid/ready handshake on both sides so the pipeline stalls on busy.

Parameters:
- XLEN, 32, operand and result width; iteration count equals XLEN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  op request from EXU
- in_ready  output  1  sequencer can accept an op
- alu_ctrl  input  5  ALU control code: 01000 mul, 01001 mulh, 01011 mulhu, 01100 div, 01101 divu, 01110 rem, 01111 remu
- src_a  input  XLEN  rs1 value
- src_b  input  XLEN  rs2 value
- flush  input  1  kill in-flight op (branch redirect/trap)
- out_valid  output  1  result available
- out_ready  input  1  pipeline consumes result
- result  output  XLEN  op result
- busy  output  1  state != IDLE

Behaviour:
- Reset: one clock and reset, clk/rst; rst is synchronous and active-high. On reset: state=IDLE, out_valid=0, result=0, busy=0, in_ready=1, iteration counter=0.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, latch alu_ctrl, src_a, src_b.
    - Next state MUL for 01000/01001/01011.
    - Next state DIV for 01100–01111.
    - Next state DONE for special cases and unsupported codes.
  - MUL: one shift-add step per edge over the operand magnitudes, producing a 2*XLEN product.
    - After the XLEN-th step, apply sign fixup; go to DONE.
  - DIV: one restoring shift-subtract step per edge over the magnitudes.
    - After the XLEN-th step, apply sign fixup; go to DONE.
  - DONE: out_valid=1, result stable. When out_ready=1, go to IDLE and drop out_valid on that edge.
- Latency (edges after the accepting edge until out_valid=1):
  - XLEN (32) for iterative ops.
  - 1 for special cases.
  - Back-to-back issue minimum: one IDLE cycle between ops. in_ready=0 in DONE.
- Sign rules:
  - mul: low XLEN bits; signedness is irrelevant.
  - mulh: signed×signed, high XLEN bits.
  - mulhu: unsigned×unsigned, high XLEN bits.
  - div/rem: negate the quotient if operand signs differ; the remainder takes the sign of the dividend.
  - divu/remu: unsigned.
- Special cases, resolved at acceptance and sent straight to DONE:
  - Divisor==0: div/divu → all ones; rem/remu → src_a.
  - Signed overflow (src_a=0x80000000, src_b=0xFFFFFFFF): div → 0x80000000; rem → 0.
  - Unsupported code (e.g. 01010, xxxx): result 0.
- flush:
  - Highest priority after rst. Next edge: state=IDLE, out_valid=0, counter=0.
  - An in_valid presented in the same cycle as flush is not accepted.
  - flush in IDLE has no effect.
- Operand inputs are sampled only at acceptance. Later changes are ignored.
- busy=1 in MUL, DIV and DONE.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined: mul/mulh/mulhu use a combinational full-width multiplier at acceptance and go IDLE→DONE in 1 edge. Divide is unchanged.
- Undefined: all multiplies use the iterative path with XLEN-edge latency. No hardware multiplier is inferred.

Test Plan:
- mul src_a=7, src_b=0xFFFFFFFD → result 0xFFFFFFEB; out_valid rises exactly 32 edges after accept (1 edge with MDU_FAST_MUL_EN).
- mulh 0x80000000×0x80000000 → 0x40000000; mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- div 0xFFFFFFF9/2 → 0xFFFFFFFD; rem same → 0xFFFFFFFF; divu 0xFFFFFFFF/0x10 → 0x0FFFFFFF; remu 100/7 → 2.
- Special cases, each with out_valid 1 edge after accept:
  - div 5/0 → 0xFFFFFFFF; rem 5/0 → 5.
  - div 0x80000000/0xFFFFFFFF → 0x80000000; rem same → 0.
- Flush:
  - Accept div, assert flush at iteration 10 → out_valid never rises; in_ready=1 next cycle.
  - A following divu 9/3 → 3 with normal latency.
  - flush together with in_valid in IDLE → op not accepted.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → result and out_valid stable, in_ready=0. Raise out_ready → IDLE next edge, in_ready=1.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle RV32M multiply/divide sequencer beside the EXU ALU.
// A shared shift/add-subtract step runs once per edge over operand magnitudes.
// Sign fixup is applied on the final step, and the result is held in DONE until it is consumed.
// Build option: define MDU_FAST_MUL_EN to resolve mul/mulh/mulhu with a
// combinational multiplier on the accepting edge (divide stays iterative).
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);

    localparam logic [4:0] OP_MUL   = 5'b01000;
    localparam logic [4:0] OP_MULH  = 5'b01001;
    localparam logic [4:0] OP_MULHU = 5'b01011;
    localparam logic [4:0] OP_DIV   = 5'b01100;
    localparam logic [4:0] OP_DIVU  = 5'b01101;
    localparam logic [4:0] OP_REM   = 5'b01110;
    localparam logic [4:0] OP_REMU  = 5'b01111;

    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_r;
    state_t state_n;

    // Registered handshake and status flags
    logic            out_valid_r;
    logic            in_ready_r;
    logic            busy_r;
    logic [XLEN-1:0] result_r;

    // Iteration datapath: hi holds partial product / remainder,
    // lo holds multiplier / dividend-then-quotient.
    logic [XLEN-1:0] hi_r;
    logic [XLEN-1:0] lo_r;
    logic [XLEN-1:0] b_r;
    logic [CW-1:0]   cnt_r;
    logic            neg_r;
    logic            sel_hi_r;
    logic            sel_rem_r;

    // Decode of the op presented at the input
    logic            is_mul_s;
    logic            is_div_s;
    logic            sgn_s;
    logic            sel_hi_s;
    logic            sel_rem_s;
    logic            neg_s;
    logic            b_zero_s;
    logic            ovf_s;
    logic            go_iter_s;
    logic            iter_mul_s;
    logic [XLEN-1:0] mag_a_s;
    logic [XLEN-1:0] mag_b_s;
    logic [XLEN-1:0] spec_res_s;
    logic [XLEN-1:0] acc_res_s;
    logic            accept_s;
    logic            last_s;

    // Shared step datapath
    logic [XLEN-1:0] hi_in_s;
    logic [XLEN-1:0] lo_in_s;
    logic [XLEN-1:0] b_in_s;
    logic            div_mode_s;
    logic [XLEN:0]   shifted_s;
    logic [XLEN+1:0] add_x_s;
    logic [XLEN+1:0] add_y_s;
    logic            add_c_s;
    logic [XLEN+1:0] sum_s;
    logic [XLEN-1:0] hi_step_s;
    logic [XLEN-1:0] lo_step_s;
    logic [XLEN-1:0] fin_res_s;

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod_s;
`endif

    // Conditional two's-complement negate
    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        if (n) begin
            neg_if = ZERO - v;
        end else begin
            neg_if = v;
        end
    endfunction

    // Sign-fix a double-width product and select the requested half
    function automatic logic [XLEN-1:0] mul_pick(input logic [2*XLEN-1:0] p,
                                                 input logic n, input logic hi);
        logic [2*XLEN-1:0] s;
        if (n) begin
            s = {(2*XLEN){1'b0}} - p;
        end else begin
            s = p;
        end
        if (hi) begin
            mul_pick = s[2*XLEN-1:XLEN];
        end else begin
            mul_pick = s[XLEN-1:0];
        end
    endfunction

    assign accept_s  = (state_r == S_IDLE) & in_valid & ~flush;
    assign last_s    = (cnt_r == CNT_LAST);
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign result    = result_r;

`ifdef MDU_FAST_MUL_EN
    assign fast_prod_s = {ZERO, mag_a_s} * {ZERO, mag_b_s};
    assign iter_mul_s  = 1'b0;
`else
    assign iter_mul_s  = 1'b1;
`endif

    // Decode the incoming op and resolve results that need no iteration
    always_comb begin
        is_mul_s  = 1'b0;
        is_div_s  = 1'b0;
        sgn_s     = 1'b0;
        sel_hi_s  = 1'b0;
        sel_rem_s = 1'b0;
        case (alu_ctrl)
            OP_MUL:   is_mul_s = 1'b1;
            OP_MULH:  begin is_mul_s = 1'b1; sgn_s = 1'b1; sel_hi_s = 1'b1; end
            OP_MULHU: begin is_mul_s = 1'b1; sel_hi_s = 1'b1; end
            OP_DIV:   begin is_div_s = 1'b1; sgn_s = 1'b1; end
            OP_DIVU:  is_div_s = 1'b1;
            OP_REM:   begin is_div_s = 1'b1; sgn_s = 1'b1; sel_rem_s = 1'b1; end
            OP_REMU:  begin is_div_s = 1'b1; sel_rem_s = 1'b1; end
            default:  is_mul_s = 1'b0;
        endcase

        mag_a_s = neg_if(src_a, sgn_s & src_a[XLEN-1]);
        mag_b_s = neg_if(src_b, sgn_s & src_b[XLEN-1]);

        // Remainder follows the dividend; quotient/product follow the sign difference
        if (sel_rem_s) begin
            neg_s = sgn_s & src_a[XLEN-1];
        end else begin
            neg_s = sgn_s & (src_a[XLEN-1] ^ src_b[XLEN-1]);
        end

        b_zero_s = (src_b == ZERO);
        ovf_s    = sgn_s & is_div_s & (src_a == MIN_NEG) & (src_b == ONES);

        if (is_div_s & b_zero_s) begin
            spec_res_s = sel_rem_s ? src_a : ONES;
        end else if (ovf_s) begin
            spec_res_s = sel_rem_s ? ZERO : MIN_NEG;
        end else begin
            spec_res_s = ZERO;
        end

        go_iter_s = (is_mul_s & iter_mul_s) | (is_div_s & ~b_zero_s & ~ovf_s);

`ifdef MDU_FAST_MUL_EN
        if (is_mul_s) begin
            acc_res_s = mul_pick(fast_prod_s, neg_s, sel_hi_s);
        end else begin
            acc_res_s = spec_res_s;
        end
`else
        acc_res_s = spec_res_s;
`endif
    end

    // One shift/add (mul) or restoring shift/subtract (div) step. The first
    // step runs on the accepting edge from fresh magnitudes, so the last of
    // the XLEN steps lands on the XLEN-th edge counted from acceptance.
    always_comb begin
        if (state_r == S_IDLE) begin
            hi_in_s    = ZERO;
            lo_in_s    = mag_a_s;
            b_in_s     = mag_b_s;
            div_mode_s = is_div_s;
        end else begin
            hi_in_s    = hi_r;
            lo_in_s    = lo_r;
            b_in_s     = b_r;
            div_mode_s = (state_r == S_DIV);
        end

        shifted_s = {hi_in_s, lo_in_s[XLEN-1]};

        if (div_mode_s) begin
            add_x_s = {1'b0, shifted_s};
            add_y_s = ~{2'b00, b_in_s};
            add_c_s = 1'b1;
        end else begin
            add_x_s = {2'b00, hi_in_s};
            add_y_s = lo_in_s[0] ? {2'b00, b_in_s} : {(XLEN+2){1'b0}};
            add_c_s = 1'b0;
        end

        sum_s = add_x_s + add_y_s + {{(XLEN+1){1'b0}}, add_c_s};

        if (div_mode_s) begin
            if (sum_s[XLEN+1]) begin
                // Trial subtract went negative: restore
                hi_step_s = shifted_s[XLEN-1:0];
                lo_step_s = {lo_in_s[XLEN-2:0], 1'b0};
            end else begin
                hi_step_s = sum_s[XLEN-1:0];
                lo_step_s = {lo_in_s[XLEN-2:0], 1'b1};
            end
            if (sel_rem_r) begin
                fin_res_s = neg_if(hi_step_s, neg_r);
            end else begin
                fin_res_s = neg_if(lo_step_s, neg_r);
            end
        end else begin
            hi_step_s = sum_s[XLEN:1];
            lo_step_s = {sum_s[0], lo_in_s[XLEN-1:1]};
            fin_res_s = mul_pick({hi_step_s, lo_step_s}, neg_r, sel_hi_r);
        end
    end

    // Next-state logic; flush overrides everything except reset
    always_comb begin
        state_n = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (is_mul_s & iter_mul_s) begin
                        state_n = S_MUL;
                    end else if (go_iter_s) begin
                        state_n = S_DIV;
                    end else begin
                        state_n = S_DONE;
                    end
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_MUL: begin
                if (last_s) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_MUL;
                end
            end
            S_DIV: begin
                if (last_s) begin
                    state_n = S_DONE;
                end else begin
                    state_n = S_DIV;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end else begin
                    state_n = S_DONE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (flush) begin
            state_n = S_IDLE;
        end else begin
            state_n = state_n;
        end
    end

    // State register plus registered flags decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            out_valid_r <= (state_n == S_DONE);
            in_ready_r  <= (state_n == S_IDLE);
            busy_r      <= (state_n != S_IDLE);
        end
    end

    // Operand capture, iteration and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r      <= ZERO;
            lo_r      <= ZERO;
            b_r       <= ZERO;
            cnt_r     <= CNT_ZERO;
            neg_r     <= 1'b0;
            sel_hi_r  <= 1'b0;
            sel_rem_r <= 1'b0;
            result_r  <= ZERO;
        end else if (flush) begin
            cnt_r <= CNT_ZERO;
        end else if (accept_s) begin
            hi_r      <= hi_step_s;
            lo_r      <= lo_step_s;
            b_r       <= mag_b_s;
            neg_r     <= neg_s;
            sel_hi_r  <= sel_hi_s;
            sel_rem_r <= sel_rem_s;
            if (go_iter_s) begin
                cnt_r <= CNT_ONE;
            end else begin
                cnt_r    <= CNT_ZERO;
                result_r <= acc_res_s;
            end
        end else if ((state_r == S_MUL) || (state_r == S_DIV)) begin
            hi_r <= hi_step_s;
            lo_r <= lo_step_s;
            if (last_s) begin
                cnt_r    <= CNT_ZERO;
                result_r <= fin_res_s;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq. Expected results are queued at
// issue and compared by a monitor at each output handshake.
`timescale 1ns/1ps
module tb_mdu_seq;

    localparam logic [4:0] C_MUL   = 5'b01000;
    localparam logic [4:0] C_MULH  = 5'b01001;
    localparam logic [4:0] C_MULHU = 5'b01011;
    localparam logic [4:0] C_DIV   = 5'b01100;
    localparam logic [4:0] C_DIVU  = 5'b01101;
    localparam logic [4:0] C_REM   = 5'b01110;
    localparam logic [4:0] C_REMU  = 5'b01111;
    localparam logic [4:0] C_BAD   = 5'b01010;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    string       mon_tag;

    mdu_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model built on native signed/unsigned arithmetic
    function automatic logic [31:0] ref_op(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic        [63:0] up;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (c)
            C_MUL:   begin up = {32'd0, a} * {32'd0, b}; return up[31:0]; end
            C_MULH:  begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
            C_MULHU: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            C_DIV:   return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sb));
            C_DIVU:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            C_REM:   return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            C_REMU:  return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            C_MUL, C_MULH, C_MULHU: return MUL_LAT;
            C_DIVU, C_REMU: return (b == 32'd0) ? 1 : 32;
            C_DIV, C_REM: return ((b == 32'd0) || ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF))) ? 1 : 32;
            default: return 1;
        endcase
    endfunction

    // Scoreboard monitor: one compare per output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check_val("sb_has_entry", 32'(exp_q.size() > 0 ? 1 : 0), 32'd1);
            if (exp_q.size() > 0) begin
                mon_tag = tag_q.pop_front();
                check_val(mon_tag, result, exp_q.pop_front());
            end
        end
    end

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check_val({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Issue one op, queue its expected result, and check its latency
    task automatic run_op(input string tag, input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int k;
        wait_ready(tag);
        alu_ctrl = c; src_a = a; src_b = b; in_valid = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk); #1;
        in_valid = 1'b0;
        src_a = $urandom; src_b = $urandom; alu_ctrl = 5'($urandom);
        k = 1;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check_val({tag, "_lat"}, 32'(k), 32'(lat));
    endtask

    task automatic watch_no_valid(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check_val(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        logic [4:0]  codes [9];
        logic [4:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        codes = '{C_MUL, C_MULH, C_MULHU, C_DIV, C_DIVU, C_REM, C_REMU, C_BAD, 5'b00000};

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        alu_ctrl = 5'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_result", result, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        // Directed arithmetic
        run_op("mul", C_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
        run_op("mulh", C_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mulhu", C_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
        run_op("div", C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32);
        run_op("rem", C_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32);
        run_op("divu", C_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32);
        run_op("remu", C_REMU, 32'd100, 32'd7, 32'd2, 32);

        // Special cases
        run_op("div_by0", C_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("rem_by0", C_REM, 32'd5, 32'd0, 32'd5, 1);
        run_op("divu_by0", C_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
        run_op("remu_by0", C_REMU, 32'd7, 32'd0, 32'd7, 1);
        run_op("div_ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf", C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        run_op("bad_code", C_BAD, 32'd3, 32'd4, 32'd0, 1);

        // Flush mid-iteration
        wait_ready("flush_div");
        alu_ctrl = C_DIV; src_a = 32'd1000; src_b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_val("flush_busy_before", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check_val("flush_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("flush_busy", {31'd0, busy}, 32'd0);
        watch_no_valid("flush_no_valid", 40);
        run_op("divu_after_flush", C_DIVU, 32'd9, 32'd3, 32'd3, 32);

        // Flush together with in_valid in IDLE
        wait_ready("flush_idle");
        alu_ctrl = C_DIVU; src_a = 32'd9; src_b = 32'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check_val("flush_idle_busy", {31'd0, busy}, 32'd0);
        check_val("flush_idle_ready", {31'd0, in_ready}, 32'd1);
        watch_no_valid("flush_idle_no_valid", 40);

        // Back-pressure in DONE
        out_ready = 1'b0;
        run_op("bp_divu", C_DIVU, 32'd1000, 32'd10, 32'd100, 32);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("bp_result%0d", i), result, 32'd100);
            check_val($sformatf("bp_valid%0d", i), {31'd0, out_valid}, 32'd1);
            check_val($sformatf("bp_in_ready%0d", i), {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check_val("bp_release_ready", {31'd0, in_ready}, 32'd1);

        // Random ops against the reference model
        for (int i = 0; i < 24; i++) begin
            c = codes[$urandom_range(0, 8)];
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
            run_op($sformatf("rnd%0d", i), c, a, b, ref_op(c, a, b), ref_lat(c, a, b));
        end

        repeat (3) @(posedge clk);
        #1;
        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
